// File: rtl/cpu_clk_pkg.sv
// Shared constants and state encoding for the CPU run/step/breakpoint clock controller.
package cpu_clk_pkg;

  localparam int CPU_DIV_W   = 26;
  localparam int CPU_DIV_DEF = 2;
  localparam int SCAN_DIV    = 200000;
  localparam int DEB_CYCLES  = 1000000;

  typedef enum logic [1:0] {
    S_HALT = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_BRK  = 2'd3
  } state_t;

endpackage

// File: rtl/cpu_clk_ctrl_if.sv
// CPU divisor configuration handshake: requester holds valid/div until ready.
interface cpu_clk_ctrl_if #(
  parameter int DIV_W = 26
) ();

  logic             valid;
  logic [DIV_W-1:0] div;
  logic             ready;

  modport master (output valid, output div, input ready);
  modport slave  (input valid, input div, output ready);

endinterface

// File: rtl/tick_gen.sv
// Programmable tick source: pulses tick when the count reaches div-1, then wraps to 0.
module tick_gen #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] div,
  output logic             tick
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] last;

  // Divisors 0 and 1 both mean a tick every enabled cycle.
  assign last = (div < WIDTH'(2)) ? '0 : div - WIDTH'(1);
  assign tick = en && (cnt_q == last);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// Run/step/breakpoint controller producing single-cycle CPU and display-scan clock enables.
//   state | meaning
//   HALT  | idle, no cpu_ce; divisor writable
//   RUN   | free-run, cpu_ce every eff_div cycles
//   STEP  | issue exactly one cpu_ce, then HALT
//   BRK   | stopped on breakpoint; divisor writable
module cpu_clk_ctrl #(
  parameter int CPU_DIV_W   = cpu_clk_pkg::CPU_DIV_W,
  parameter int CPU_DIV_DEF = cpu_clk_pkg::CPU_DIV_DEF,
  parameter int SCAN_DIV    = cpu_clk_pkg::SCAN_DIV,
  parameter int DEB_CYCLES  = cpu_clk_pkg::DEB_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run_sw,
  input  logic                 step_btn,
  input  logic                 brk,
  cpu_clk_ctrl_if.slave        cfg,
  output logic                 cpu_ce,
  output logic                 scan_ce,
  output logic                 halted,
  output logic [31:0]          cycle_cnt
);

  import cpu_clk_pkg::*;

  localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
  localparam int SCAN_W = $clog2(SCAN_DIV + 1);

  state_t               state_q, state_d;
  logic                 run_s1_q, run_s_q, btn_s1_q, btn_s_q;
  logic                 deb_q, deb_d, deb_dly_q;
  logic [DEB_W-1:0]     deb_cnt_q, deb_cnt_d;
  logic [CPU_DIV_W-1:0] div_q, div_d;
  logic                 cpu_ce_q, cpu_ce_d;
  logic                 scan_ce_q;
  logic [31:0]          cycle_cnt_q, cycle_cnt_d;
  logic                 step_req, cpu_tick, scan_tick;
  logic                 cpu_en, cpu_clr, halted_w;

  // Debounce: deb follows btn_s only after it has differed for DEB_CYCLES cycles in a row.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (btn_s_q != deb_q) begin
      if (deb_cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
        deb_d = btn_s_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end
  end

  assign step_req = deb_q && !deb_dly_q;
  assign halted_w = (state_q == S_HALT) || (state_q == S_BRK);
  assign cpu_en   = (state_q == S_RUN) || (state_q == S_STEP);
  assign cpu_clr  = ((state_d == S_RUN) || (state_d == S_STEP)) && (state_d != state_q);

  always_comb begin
    state_d  = state_q;
    cpu_ce_d = 1'b0;
    unique case (state_q)
      S_HALT: begin
        if (run_s_q)       state_d = S_RUN;
        else if (step_req) state_d = S_STEP;
      end
      S_RUN: begin
        if (!run_s_q)              state_d = S_HALT;
        else if (cpu_tick && brk)  state_d = S_BRK;
        else if (cpu_tick)         cpu_ce_d = 1'b1;
      end
      S_STEP: begin
        if (cpu_tick) begin
          cpu_ce_d = 1'b1;
          state_d  = S_HALT;
        end
      end
      S_BRK: begin
        if (!run_s_q)      state_d = S_HALT;
        else if (step_req) state_d = S_STEP;
      end
      default: state_d = S_HALT;
    endcase
  end

  assign cycle_cnt_d = cycle_cnt_q + 32'(cpu_ce_d);
  assign div_d       = (cfg.valid && halted_w) ? cfg.div : div_q;

  tick_gen #(.WIDTH(CPU_DIV_W)) u_cpu_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (cpu_en),
    .clr  (cpu_clr),
    .div  (div_q),
    .tick (cpu_tick)
  );

  tick_gen #(.WIDTH(SCAN_W)) u_scan_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (1'b1),
    .clr  (1'b0),
    .div  (SCAN_W'(SCAN_DIV)),
    .tick (scan_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_HALT;
      run_s1_q    <= 1'b0;
      run_s_q     <= 1'b0;
      btn_s1_q    <= 1'b0;
      btn_s_q     <= 1'b0;
      deb_q       <= 1'b0;
      deb_dly_q   <= 1'b0;
      deb_cnt_q   <= '0;
      div_q       <= CPU_DIV_W'(CPU_DIV_DEF);
      cpu_ce_q    <= 1'b0;
      scan_ce_q   <= 1'b0;
      cycle_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      run_s1_q    <= run_sw;
      run_s_q     <= run_s1_q;
      btn_s1_q    <= step_btn;
      btn_s_q     <= btn_s1_q;
      deb_q       <= deb_d;
      deb_dly_q   <= deb_q;
      deb_cnt_q   <= deb_cnt_d;
      div_q       <= div_d;
      cpu_ce_q    <= cpu_ce_d;
      scan_ce_q   <= scan_tick;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign cpu_ce    = cpu_ce_q;
  assign scan_ce   = scan_ce_q;
  assign halted    = halted_w;
  assign cycle_cnt = cycle_cnt_q;
  assign cfg.ready = halted_w;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed self-checking bench for cpu_clk_ctrl (DEB_CYCLES=4, SCAN_DIV=8).
module tb_cpu_clk_ctrl;

  logic        clk;
  logic        rst;
  logic        run_sw;
  logic        step_btn;
  logic        brk;
  logic        cpu_ce;
  logic        scan_ce;
  logic        halted;
  logic [31:0] cycle_cnt;

  int n_assert = 0;
  int n_fail   = 0;
  int n;

  cpu_clk_ctrl_if #(.DIV_W(26)) cfg_if ();

  cpu_clk_ctrl #(
    .CPU_DIV_W   (26),
    .CPU_DIV_DEF (2),
    .SCAN_DIV    (8),
    .DEB_CYCLES  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .run_sw    (run_sw),
    .step_btn  (step_btn),
    .brk       (brk),
    .cfg       (cfg_if),
    .cpu_ce    (cpu_ce),
    .scan_ce   (scan_ce),
    .halted    (halted),
    .cycle_cnt (cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Negedges until the next cpu_ce, -1 if none within max.
  task automatic wait_ce(input int max, output int cnt);
    cnt = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (cpu_ce) begin
        cnt = i;
        break;
      end
    end
  endtask

  task automatic wait_scan(input int max, output int cnt);
    cnt = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (scan_ce) begin
        cnt = i;
        break;
      end
    end
  endtask

  task automatic count_ce(input int k, output int cnt);
    cnt = 0;
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      if (cpu_ce) cnt++;
    end
  endtask

  initial begin
    rst          = 1'b1;
    run_sw       = 1'b0;
    step_btn     = 1'b0;
    brk          = 1'b0;
    cfg_if.valid = 1'b0;
    cfg_if.div   = '0;
    cyc(2);
    chk("rst_halted", 32'(halted), 32'd1);
    chk("rst_ready", 32'(cfg_if.ready), 32'd1);
    chk("rst_cpu_ce", 32'(cpu_ce), 32'd0);
    chk("rst_scan_ce", 32'(scan_ce), 32'd0);
    chk("rst_cycle_cnt", cycle_cnt, 32'd0);

    // 1: free run at default divisor 2
    rst    = 1'b0;
    run_sw = 1'b1;
    wait_ce(20, n); chk("run_first_ce", 32'(n), 32'd5);
    for (int i = 0; i < 9; i++) begin
      wait_ce(20, n); chk("run_ce_period2", 32'(n), 32'd2);
    end
    chk("run_cnt10", cycle_cnt, 32'd10);
    chk("run_halted", 32'(halted), 32'd0);
    run_sw = 1'b0;
    count_ce(8, n); chk("stop_tail_ce", 32'(n), 32'd1);
    chk("stop_cnt", cycle_cnt, 32'd11);
    chk("stop_halted", 32'(halted), 32'd1);

    // 2: single step and glitch rejection
    step_btn = 1'b1;
    cyc(6);
    step_btn = 1'b0;
    wait_ce(20, n); chk("step_ce_time", 32'(n), 32'd3);
    chk("step_back_halt", 32'(halted), 32'd1);
    chk("step_cnt", cycle_cnt, 32'd12);
    count_ce(8, n); chk("step_single", 32'(n), 32'd0);
    step_btn = 1'b1;
    cyc(2);
    step_btn = 1'b0;
    count_ce(12, n); chk("glitch_no_step", 32'(n), 32'd0);
    chk("glitch_cnt", cycle_cnt, 32'd12);

    // 3: breakpoint suppresses the tick, step walks over it
    run_sw = 1'b1;
    wait_ce(20, n); chk("brk_run_ce", 32'(n), 32'd5);
    brk = 1'b1;
    count_ce(6, n); chk("brk_suppress", 32'(n), 32'd0);
    chk("brk_halted", 32'(halted), 32'd1);
    chk("brk_cnt", cycle_cnt, 32'd13);
    step_btn = 1'b1;
    cyc(6);
    step_btn = 1'b0;
    wait_ce(20, n); chk("brk_step_ce", 32'(n), 32'd3);
    chk("brk_step_halt", 32'(halted), 32'd1);
    chk("brk_step_cnt", cycle_cnt, 32'd14);
    run_sw = 1'b0;
    brk    = 1'b0;
    count_ce(8, n); chk("brk_exit_quiet", 32'(n), 32'd0);
    chk("brk_exit_halted", 32'(halted), 32'd1);

    // 4: divisor write in HALT, blocked while running
    cfg_if.valid = 1'b1;
    cfg_if.div   = 26'd5;
    chk("cfg_ready_halt", 32'(cfg_if.ready), 32'd1);
    cyc(1);
    cfg_if.valid = 1'b0;
    run_sw = 1'b1;
    wait_ce(20, n); chk("div5_first", 32'(n), 32'd8);
    wait_ce(20, n); chk("div5_period_a", 32'(n), 32'd5);
    wait_ce(20, n); chk("div5_period_b", 32'(n), 32'd5);
    cfg_if.valid = 1'b1;
    cfg_if.div   = 26'd3;
    chk("cfg_ready_run", 32'(cfg_if.ready), 32'd0);
    wait_ce(20, n); chk("div_unchanged", 32'(n), 32'd5);
    run_sw = 1'b0;
    cyc(6);
    chk("cfg_ready_after", 32'(cfg_if.ready), 32'd1);
    chk("div_cnt18", cycle_cnt, 32'd18);
    cfg_if.valid = 1'b0;
    run_sw = 1'b1;
    wait_ce(20, n); chk("div3_first", 32'(n), 32'd6);
    wait_ce(20, n); chk("div3_period", 32'(n), 32'd3);
    run_sw = 1'b0;
    count_ce(6, n); chk("div3_stop", 32'(n), 32'd0);
    chk("div_cnt20", cycle_cnt, 32'd20);

    // 5: divisors 0 and 1 tick every cycle; cycle_cnt wraps
    cfg_if.valid = 1'b1;
    cfg_if.div   = 26'd0;
    cyc(1);
    cfg_if.valid = 1'b0;
    force dut.cycle_cnt_q = 32'hFFFF_FFFD;
    cyc(1);
    release dut.cycle_cnt_q;
    run_sw = 1'b1;
    wait_ce(20, n); chk("div0_first", 32'(n), 32'd4);
    chk("wrap_fffe", cycle_cnt, 32'hFFFF_FFFE);
    wait_ce(20, n); chk("div0_back2back_a", 32'(n), 32'd1);
    chk("wrap_ffff", cycle_cnt, 32'hFFFF_FFFF);
    wait_ce(20, n); chk("div0_back2back_b", 32'(n), 32'd1);
    chk("wrap_zero", cycle_cnt, 32'd0);
    run_sw = 1'b0;
    count_ce(6, n); chk("div0_stop_tail", 32'(n), 32'd2);
    chk("wrap_cnt2", cycle_cnt, 32'd2);
    cfg_if.valid = 1'b1;
    cfg_if.div   = 26'd1;
    cyc(1);
    cfg_if.valid = 1'b0;
    run_sw = 1'b1;
    wait_ce(20, n); chk("div1_first", 32'(n), 32'd4);
    count_ce(5, n); chk("div1_every_cycle", 32'(n), 32'd5);
    run_sw = 1'b0;
    count_ce(6, n); chk("div1_stop_tail", 32'(n), 32'd2);
    chk("div1_cnt", cycle_cnt, 32'd10);

    // 6: async reset mid-run, scan resumes and divisor returns to default
    run_sw = 1'b1;
    wait_ce(20, n); chk("pre_rst_ce", 32'(n), 32'd4);
    #2 rst = 1'b1;
    #1;
    chk("arst_cpu_ce", 32'(cpu_ce), 32'd0);
    chk("arst_cnt", cycle_cnt, 32'd0);
    chk("arst_halted", 32'(halted), 32'd1);
    chk("arst_ready", 32'(cfg_if.ready), 32'd1);
    chk("arst_scan_ce", 32'(scan_ce), 32'd0);
    run_sw = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    wait_scan(20, n); chk("scan_first", 32'(n), 32'd8);
    wait_scan(20, n); chk("scan_period", 32'(n), 32'd8);
    chk("post_rst_quiet", cycle_cnt, 32'd0);
    run_sw = 1'b1;
    wait_ce(20, n); chk("post_rst_div_def", 32'(n), 32'd5);
    run_sw = 1'b0;
    cyc(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
